// File: rtl/ddr2_app_pkg.sv
// rtl/ddr2_app_pkg.sv - shared codes, widths and engine states for the DDR2 app-port BRAM responder
// Purpose: command codes, line/mask widths, execution-engine state encoding.
// Ports: none (package).
package ddr2_app_pkg;

    localparam int LINE_W = 128;
    localparam int MASK_W = 16;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        ST_CALIB,
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR_COMMIT,
        ST_RD_ACCESS,
        ST_RD_DELAY,
        ST_BEAT_L,
        ST_BEAT_H
    } eng_state_e;

    function automatic logic cmd_is_valid(input logic [2:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/ddr2_app_bram_responder_if.sv
// rtl/ddr2_app_bram_responder_if.sv - app-port bundle between a DDR2 user and the BRAM responder
// Purpose: groups the command, write-data, read-data, status and stall signals.
// Ports: master = user side (drives command/write data/stall),
//        slave  = responder side (drives ready, read data, calibration, error).
interface ddr2_app_bram_responder_if;

    logic [26:0] app_addr_i;
    logic [2:0]  app_cmd_i;
    logic        app_en_i;
    logic        app_rdy_o;
    logic [63:0] app_wdf_data_i;
    logic [7:0]  app_wdf_mask_i;
    logic        app_wdf_wren_i;
    logic        app_wdf_end_i;
    logic        app_wdf_rdy_o;
    logic [63:0] app_rd_data_o;
    logic        app_rd_data_valid_o;
    logic        app_rd_data_end_o;
    logic        init_calib_complete_o;
    logic        stall_i;
    logic        protocol_error_o;

    modport master (
        output app_addr_i, app_cmd_i, app_en_i,
        output app_wdf_data_i, app_wdf_mask_i, app_wdf_wren_i, app_wdf_end_i,
        output stall_i,
        input  app_rdy_o, app_wdf_rdy_o,
        input  app_rd_data_o, app_rd_data_valid_o, app_rd_data_end_o,
        input  init_calib_complete_o, protocol_error_o
    );

    modport slave (
        input  app_addr_i, app_cmd_i, app_en_i,
        input  app_wdf_data_i, app_wdf_mask_i, app_wdf_wren_i, app_wdf_end_i,
        input  stall_i,
        output app_rdy_o, app_wdf_rdy_o,
        output app_rd_data_o, app_rd_data_valid_o, app_rd_data_end_o,
        output init_calib_complete_o, protocol_error_o
    );

endinterface

// File: rtl/ddr2_app_fifo.sv
// rtl/ddr2_app_fifo.sv - synchronous first-word-fall-through FIFO used for command and write-data queues
// Purpose: parameterized WIDTH x DEPTH queue; head entry visible on pop_data_o while not empty.
// Ports: clk_i/rst_i (sync active-high), push_i/push_data_i, pop_i/pop_data_o, full_o, empty_o.
module ddr2_app_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full queue is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) count_d = count_q + CW'(1);
        if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= bump(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= bump(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ddr2_app_bram_responder.sv
// rtl/ddr2_app_bram_responder.sv - DDR2 app-port model answering from an internal 128-bit line array
// Purpose: calibration delay, in-order command execution against a block-RAM array,
//          two-beat write assembly, fixed-latency two-beat reads, sticky protocol error.
// Ports: ui_clk_i (clock), ui_rst_i (sync active-high reset), app (slave side of the app bundle).
module ddr2_app_bram_responder
    import ddr2_app_pkg::*;
#(
    parameter int MEM_AW       = 10,
    parameter int CALIB_CYCLES = 64,
    parameter int RD_LAT       = 2,
    parameter int CMD_DEPTH    = 4
) (
    input  logic                        ui_clk_i,
    input  logic                        ui_rst_i,
    ddr2_app_bram_responder_if.slave    app
);

    localparam int CMD_W = MEM_AW + 1;
    localparam int WDF_W = LINE_W + MASK_W;
    localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
    localparam int DLY_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    eng_state_e         state_q;
    logic [CAL_W-1:0]   calib_cnt_q;
    logic               calib_q;
    logic [DLY_W-1:0]   dly_cnt_q;
    logic [63:0]        rd_data_q;
    logic               rd_valid_q, rd_end_q, err_q;
    logic               pair_hi_q;
    logic [63:0]        lo_data_q;
    logic [7:0]         lo_mask_q;
    logic [LINE_W-1:0]  rd_line_q;
    logic [LINE_W-1:0]  array_mem [2**MEM_AW];

    logic               app_rdy, wdf_rdy, cmd_accept, cmd_ok, beat_accept;
    logic               cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic               wdf_push, wdf_pop, wdf_full, wdf_empty;
    logic [CMD_W-1:0]   cmd_head;
    logic [WDF_W-1:0]   wdf_head;
    logic [MEM_AW-1:0]  head_addr;
    logic               head_is_read;
    logic [LINE_W-1:0]  wr_line;
    logic [MASK_W-1:0]  wr_mask;

    assign app_rdy     = calib_q & ~app.stall_i & ~cmd_full;
    assign wdf_rdy     = calib_q & ~app.stall_i & ~wdf_full;
    assign cmd_accept  = app.app_en_i & app_rdy;
    assign cmd_ok      = cmd_is_valid(app.app_cmd_i);
    // Unknown command codes are swallowed: accepted but never queued.
    assign cmd_push    = cmd_accept & cmd_ok;
    assign beat_accept = app.app_wdf_wren_i & wdf_rdy;
    // A line is queued only once its high half arrives.
    assign wdf_push    = beat_accept & pair_hi_q;
    assign cmd_pop     = (state_q == ST_WR_COMMIT) || (state_q == ST_RD_ACCESS);
    assign wdf_pop     = (state_q == ST_WR_COMMIT);

    assign head_addr    = cmd_head[MEM_AW-1:0];
    assign head_is_read = cmd_head[MEM_AW];
    assign wr_line      = wdf_head[WDF_W-1:MASK_W];
    assign wr_mask      = wdf_head[MASK_W-1:0];

    ddr2_app_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i       (ui_clk_i),
        .rst_i       (ui_rst_i),
        .push_i      (cmd_push),
        .push_data_i ({app.app_cmd_i == CMD_READ, app.app_addr_i[MEM_AW+3:4]}),
        .pop_i       (cmd_pop),
        .pop_data_o  (cmd_head),
        .full_o      (cmd_full),
        .empty_o     (cmd_empty)
    );

    ddr2_app_fifo #(.WIDTH(WDF_W), .DEPTH(2)) u_wdf_fifo (
        .clk_i       (ui_clk_i),
        .rst_i       (ui_rst_i),
        .push_i      (wdf_push),
        .push_data_i ({app.app_wdf_data_i, lo_data_q, app.app_wdf_mask_i, lo_mask_q}),
        .pop_i       (wdf_pop),
        .pop_data_o  (wdf_head),
        .full_o      (wdf_full),
        .empty_o     (wdf_empty)
    );

    // Array has no reset: contents survive ui_rst_i.
    always_ff @(posedge ui_clk_i) begin
        if (state_q == ST_WR_COMMIT && !ui_rst_i) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!wr_mask[b]) array_mem[head_addr][b*8 +: 8] <= wr_line[b*8 +: 8];
            end
        end
        if (state_q == ST_RD_ACCESS) rd_line_q <= array_mem[head_addr];
    end

    always_ff @(posedge ui_clk_i) begin
        if (ui_rst_i) begin
            state_q     <= ST_CALIB;
            calib_cnt_q <= '0;
            calib_q     <= 1'b0;
            dly_cnt_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_end_q    <= 1'b0;
            err_q       <= 1'b0;
            pair_hi_q   <= 1'b0;
            lo_data_q   <= '0;
            lo_mask_q   <= '0;
        end else begin
            if (!calib_q) begin
                if (calib_cnt_q == CAL_W'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
                else                                          calib_cnt_q <= calib_cnt_q + CAL_W'(1);
            end

            if (cmd_accept && !cmd_ok) err_q <= 1'b1;

            // Beats keep their pair position even when end is wrong; only the flag records it.
            if (beat_accept) begin
                if (!pair_hi_q) begin
                    lo_data_q <= app.app_wdf_data_i;
                    lo_mask_q <= app.app_wdf_mask_i;
                    if (app.app_wdf_end_i) err_q <= 1'b1;
                end else if (!app.app_wdf_end_i) begin
                    err_q <= 1'b1;
                end
                pair_hi_q <= ~pair_hi_q;
            end

            rd_valid_q <= 1'b0;
            rd_end_q   <= 1'b0;

            case (state_q)
                ST_CALIB:     if (calib_q) state_q <= ST_IDLE;
                ST_IDLE:      if (!cmd_empty) state_q <= head_is_read ? ST_RD_ACCESS : ST_WR_WAIT;
                ST_WR_WAIT:   if (!wdf_empty) state_q <= ST_WR_COMMIT;
                ST_WR_COMMIT: state_q <= ST_IDLE;
                ST_RD_ACCESS: begin
                    dly_cnt_q <= '0;
                    state_q   <= (RD_LAT == 0) ? ST_BEAT_L : ST_RD_DELAY;
                end
                ST_RD_DELAY: begin
                    if (dly_cnt_q == DLY_W'(RD_LAT - 1)) state_q <= ST_BEAT_L;
                    else                                  dly_cnt_q <= dly_cnt_q + DLY_W'(1);
                end
                // Read outputs are registered, so each beat appears one cycle after its state.
                ST_BEAT_L: begin
                    rd_data_q  <= rd_line_q[63:0];
                    rd_valid_q <= 1'b1;
                    state_q    <= ST_BEAT_H;
                end
                ST_BEAT_H: begin
                    rd_data_q  <= rd_line_q[127:64];
                    rd_valid_q <= 1'b1;
                    rd_end_q   <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default:      state_q <= ST_CALIB;
            endcase
        end
    end

    assign app.app_rdy_o             = app_rdy;
    assign app.app_wdf_rdy_o         = wdf_rdy;
    assign app.app_rd_data_o         = rd_data_q;
    assign app.app_rd_data_valid_o   = rd_valid_q;
    assign app.app_rd_data_end_o     = rd_end_q;
    assign app.init_calib_complete_o = calib_q;
    assign app.protocol_error_o      = err_q;

endmodule

// File: tb/tb_ddr2_app_bram_responder.sv
// tb/tb_ddr2_app_bram_responder.sv - directed self-checking bench for ddr2_app_bram_responder
module tb_ddr2_app_bram_responder;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    ddr2_app_bram_responder_if bus();

    ddr2_app_bram_responder #(
        .MEM_AW       (10),
        .CALIB_CYCLES (64),
        .RD_LAT       (2),
        .CMD_DEPTH    (4)
    ) dut (
        .ui_clk_i (clk),
        .ui_rst_i (rst),
        .app      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] cmd, input logic [26:0] addr);
        int n;
        n = 0;
        bus.app_cmd_i  = cmd;
        bus.app_addr_i = addr;
        bus.app_en_i   = 1'b1;
        while (!bus.app_rdy_o && n < 300) begin
            tick();
            n++;
        end
        if (!bus.app_rdy_o) check("cmd_rdy_timeout", bus.app_rdy_o, 64'd1);
        tick();
        bus.app_en_i = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] data, input logic [7:0] mask, input logic last);
        int n;
        n = 0;
        bus.app_wdf_data_i = data;
        bus.app_wdf_mask_i = mask;
        bus.app_wdf_end_i  = last;
        bus.app_wdf_wren_i = 1'b1;
        while (!bus.app_wdf_rdy_o && n < 300) begin
            tick();
            n++;
        end
        if (!bus.app_wdf_rdy_o) check("wdf_rdy_timeout", bus.app_wdf_rdy_o, 64'd1);
        tick();
        bus.app_wdf_wren_i = 1'b0;
        bus.app_wdf_end_i  = 1'b0;
    endtask

    task automatic do_read(input logic [26:0] addr, input logic [63:0] exp_lo, input logic [63:0] exp_hi);
        int n;
        n = 0;
        send_cmd(3'b001, addr);
        while (!bus.app_rd_data_valid_o && n < 50) begin
            tick();
            n++;
        end
        check("rd_latency", 64'(n), 64'd5);
        check("rd_lo_data", bus.app_rd_data_o, exp_lo);
        check("rd_lo_end", bus.app_rd_data_end_o, 64'd0);
        tick();
        check("rd_hi_valid", bus.app_rd_data_valid_o, 64'd1);
        check("rd_hi_data", bus.app_rd_data_o, exp_hi);
        check("rd_hi_end", bus.app_rd_data_end_o, 64'd1);
        tick();
        check("rd_after_valid", bus.app_rd_data_valid_o, 64'd0);
        check("rd_hold_data", bus.app_rd_data_o, exp_hi);
    endtask

    // Counts 64 cycles from reset release; calibration must rise on exactly the 64th.
    task automatic calib_check(input string tag);
        logic early;
        logic seen_valid;
        early      = 1'b0;
        seen_valid = 1'b0;
        for (int i = 1; i <= 63; i++) begin
            tick();
            if (bus.init_calib_complete_o || bus.app_rdy_o || bus.app_wdf_rdy_o) early = 1'b1;
            if (bus.app_rd_data_valid_o) seen_valid = 1'b1;
        end
        check({tag, "_early"}, early, 64'd0);
        check({tag, "_no_valid"}, seen_valid, 64'd0);
        tick();
        check({tag, "_calib64"}, bus.init_calib_complete_o, 64'd1);
        check({tag, "_rdy64"}, bus.app_rdy_o, 64'd1);
    endtask

    initial begin
        logic [63:0] lo_k;
        logic [63:0] hi_k;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        bus.app_addr_i     = '0;
        bus.app_cmd_i      = '0;
        bus.app_en_i       = 1'b0;
        bus.app_wdf_data_i = '0;
        bus.app_wdf_mask_i = '0;
        bus.app_wdf_wren_i = 1'b0;
        bus.app_wdf_end_i  = 1'b0;
        bus.stall_i        = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_calib", bus.init_calib_complete_o, 64'd0);
        check("rst_rdy", bus.app_rdy_o, 64'd0);
        check("rst_wdf_rdy", bus.app_wdf_rdy_o, 64'd0);
        check("rst_valid", bus.app_rd_data_valid_o, 64'd0);
        check("rst_end", bus.app_rd_data_end_o, 64'd0);
        check("rst_data", bus.app_rd_data_o, 64'd0);
        check("rst_err", bus.protocol_error_o, 64'd0);
        rst = 1'b0;
        calib_check("boot");

        // stall forces both readies low
        bus.stall_i = 1'b1;
        #1;
        check("stall_rdy", bus.app_rdy_o, 64'd0);
        check("stall_wdf_rdy", bus.app_wdf_rdy_o, 64'd0);
        bus.stall_i = 1'b0;
        tick();

        // Write then read back, address low bits ignored
        send_cmd(3'b000, 27'h000_0120);
        send_beat(64'h1111111111111111, 8'h00, 1'b0);
        send_beat(64'h2222222222222222, 8'h00, 1'b1);
        repeat (5) tick();
        do_read(27'h000_0125, 64'h1111111111111111, 64'h2222222222222222);

        // Byte mask: only byte 0 written; write data arrives before its command
        send_beat(64'hCDCDCDCDCDCDCDAB, 8'hFE, 1'b0);
        send_beat(64'hCDCDCDCDCDCDCDCD, 8'hFF, 1'b1);
        send_cmd(3'b000, 27'h000_0120);
        repeat (5) tick();
        do_read(27'h000_0120, 64'h11111111111111AB, 64'h2222222222222222);

        // Upper address bits alias onto the same line
        do_read(27'h7FF_C120, 64'h11111111111111AB, 64'h2222222222222222);

        // Command FIFO fills with data-less writes
        for (int k = 0; k < 4; k++) send_cmd(3'b000, 27'h200 + 27'(k * 16));
        bus.app_cmd_i  = 3'b001;
        bus.app_addr_i = 27'h230;
        bus.app_en_i   = 1'b1;
        tick();
        check("full_rdy_a", bus.app_rdy_o, 64'd0);
        tick();
        check("full_rdy_b", bus.app_rdy_o, 64'd0);
        bus.app_en_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lo_k = 64'hA5A5000000000000 + 64'(k);
            hi_k = 64'h5A5A000000000000 + 64'(k);
            send_beat(lo_k, 8'h00, 1'b0);
            send_beat(hi_k, 8'h00, 1'b1);
        end
        repeat (10) tick();
        check("drain_rdy", bus.app_rdy_o, 64'd1);
        check("drain_err", bus.protocol_error_o, 64'd0);
        do_read(27'h200, 64'hA5A5000000000000, 64'h5A5A000000000000);
        do_read(27'h230, 64'hA5A5000000000003, 64'h5A5A000000000003);

        // Wrong end flag on a first beat sets the sticky error
        send_beat(64'h0, 8'hFF, 1'b1);
        check("beat_err", bus.protocol_error_o, 64'd1);
        send_beat(64'h0, 8'hFF, 1'b1);
        repeat (10) tick();
        check("beat_err_sticky", bus.protocol_error_o, 64'd1);

        // Reset between read acceptance and its first beat
        send_cmd(3'b001, 27'h120);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_valid", bus.app_rd_data_valid_o, 64'd0);
        check("mid_rst_err", bus.protocol_error_o, 64'd0);
        check("mid_rst_data", bus.app_rd_data_o, 64'd0);
        rst = 1'b0;
        calib_check("recal");

        // Illegal command code
        send_cmd(3'b010, 27'h0);
        check("cmd_err", bus.protocol_error_o, 64'd1);
        repeat (3) tick();
        check("cmd_err_sticky", bus.protocol_error_o, 64'd1);

        // Array survives reset; discarded command left the queue empty
        do_read(27'h120, 64'h11111111111111AB, 64'h2222222222222222);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
